int_div_issue_queue: RTL

- Buffers divide/remainder requests from the execute dispatch stage and issues them in order to the integer divider.
- Records each issued request's destination tag in an in-flight queue and pairs the divider result with that tag on a writeback valid/ready port.
- Handles pipeline flush: queued requests are dropped, and results of already-issued requests are consumed and discarded.

---
 rtl/int_div_issue_queue_if.sv | 35 +++
 rtl/int_div_issue_queue.sv | 107 ++++++++++
 2 files changed

// File: rtl/int_div_issue_queue_if.sv
// rtl/int_div_issue_queue_if.sv - dispatch, divider and writeback signal bundle for int_div_issue_queue
interface int_div_issue_queue_if #(
    parameter int n     = 32,
    parameter int TAG_W = 5
);
    logic             flush;
    logic             valid_in;
    logic             ready_out;
    logic [1:0]       op;
    logic [n-1:0]     a;
    logic [n-1:0]     b;
    logic [TAG_W-1:0] tag_in;
    logic             div_valid;
    logic             div_ready;
    logic [1:0]       div_op;
    logic [n-1:0]     div_a;
    logic [n-1:0]     div_b;
    logic             div_res_valid;
    logic             div_res_ready;
    logic [n-1:0]     div_y;
    logic             wb_valid;
    logic             wb_ready;
    logic [TAG_W-1:0] wb_tag;
    logic [n-1:0]     wb_data;

    modport master (
        output flush, valid_in, op, a, b, tag_in, div_ready, div_res_valid, div_y, wb_ready,
        input  ready_out, div_valid, div_op, div_a, div_b, div_res_ready, wb_valid, wb_tag, wb_data
    );

    modport slave (
        input  flush, valid_in, op, a, b, tag_in, div_ready, div_res_valid, div_y, wb_ready,
        output ready_out, div_valid, div_op, div_a, div_b, div_res_ready, wb_valid, wb_tag, wb_data
    );
endinterface

// File: rtl/int_div_issue_queue.sv
// rtl/int_div_issue_queue.sv - in-order divide issue queue with tagged writeback; INT_DIV_ISSUE_BYPASS_EN enables empty-queue bypass
module int_div_issue_queue #(
    parameter int n         = 32,
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 5,
    parameter int IFQ_DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    int_div_issue_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(IFQ_DEPTH);

    typedef struct packed {
        logic [1:0]       op;
        logic [n-1:0]     a;
        logic [n-1:0]     b;
        logic [TAG_W-1:0] tag;
    } req_t;

    req_t                 rq_mem [DEPTH];
    logic [AW:0]          rq_wr;
    logic [AW:0]          rq_rd;
    logic [TAG_W-1:0]     ifq_tag [IFQ_DEPTH];
    logic [IFQ_DEPTH-1:0] ifq_kill;
    logic [IW:0]          ifq_wr;
    logic [IW:0]          ifq_rd;

    logic rq_empty, rq_full, ifq_empty, ifq_full;
    logic rq_push, rq_pop, issue, ifq_pop, head_killed, issue_ok;
    req_t req_in, rq_head, issue_req;
`ifdef INT_DIV_ISSUE_BYPASS_EN
    logic bypass;
`endif

    always_comb begin
        rq_empty  = (rq_wr == rq_rd);
        rq_full   = (rq_wr[AW] != rq_rd[AW]) && (rq_wr[AW-1:0] == rq_rd[AW-1:0]);
        ifq_empty = (ifq_wr == ifq_rd);
        ifq_full  = (ifq_wr[IW] != ifq_rd[IW]) && (ifq_wr[IW-1:0] == ifq_rd[IW-1:0]);
        req_in    = {bus.op, bus.a, bus.b, bus.tag_in};
        rq_head   = rq_mem[rq_rd[AW-1:0]];
        issue_ok  = !reset && !bus.flush && !ifq_full;

        bus.ready_out = !reset && !rq_full && !bus.flush;
`ifdef INT_DIV_ISSUE_BYPASS_EN
        // An empty queue lets the incoming request go straight to the divider.
        bypass        = issue_ok && rq_empty;
        bus.div_valid = issue_ok && (rq_empty ? bus.valid_in : 1'b1);
        issue_req     = bypass ? req_in : rq_head;
        issue         = bus.div_valid && bus.div_ready;
        rq_push       = bus.valid_in && bus.ready_out && !(bypass && bus.div_ready);
        rq_pop        = issue && !bypass;
`else
        bus.div_valid = issue_ok && !rq_empty;
        issue_req     = rq_head;
        issue         = bus.div_valid && bus.div_ready;
        rq_push       = bus.valid_in && bus.ready_out;
        rq_pop        = issue;
`endif
        bus.div_op = issue_req.op;
        bus.div_a  = issue_req.a;
        bus.div_b  = issue_req.b;

        // A result arriving during flush belongs to a request being killed.
        head_killed       = bus.flush || ifq_kill[ifq_rd[IW-1:0]];
        bus.wb_valid      = !reset && bus.div_res_valid && !ifq_empty && !head_killed;
        bus.wb_tag        = ifq_tag[ifq_rd[IW-1:0]];
        bus.wb_data       = bus.div_y;
        bus.div_res_ready = !reset && (head_killed || bus.wb_ready);
        ifq_pop           = bus.div_res_valid && bus.div_res_ready && !ifq_empty;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rq_wr    <= '0;
            rq_rd    <= '0;
            ifq_wr   <= '0;
            ifq_rd   <= '0;
            ifq_kill <= '0;
            for (int i = 0; i < DEPTH; i++) rq_mem[i] <= '0;
            for (int i = 0; i < IFQ_DEPTH; i++) ifq_tag[i] <= '0;
        end else begin
            if (bus.flush) begin
                rq_wr <= '0;
                rq_rd <= '0;
            end else begin
                if (rq_push) begin
                    rq_mem[rq_wr[AW-1:0]] <= req_in;
                    rq_wr                 <= rq_wr + (AW+1)'(1);
                end
                if (rq_pop) rq_rd <= rq_rd + (AW+1)'(1);
            end
            if (issue) begin
                ifq_tag[ifq_wr[IW-1:0]] <= issue_req.tag;
                ifq_wr                  <= ifq_wr + (IW+1)'(1);
            end
            if (ifq_pop) ifq_rd <= ifq_rd + (IW+1)'(1);
            // Issue never coincides with flush, so the two kill updates are exclusive.
            if (bus.flush) ifq_kill <= '1;
            else if (issue) ifq_kill[ifq_wr[IW-1:0]] <= 1'b0;
        end
    end

    res_needs_issue: assert property (@(posedge clk) disable iff (reset) !(bus.div_res_valid && ifq_empty));
endmodule
